// File: rtl/ram_checker_if.sv
// ram_checker_if: RAM pin bundle between the BIST initiator and the RAM.
// master = checker side (drives en/we/addr/din); slave = RAM side.
interface ram_checker_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (output ram_en, ram_we, ram_addr, ram_din, input ram_dout);
    modport slave  (input ram_en, ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/ram_checker.sv
// ram_checker: BIST initiator for a single-port RAM.
// Writes a selectable pattern to every address, reads it all back and
// compares, reporting pass, error count and first failing address.
// Optional macro RAM_CHECKER_INV_PASS_EN adds a second pass using the
// bitwise-inverted pattern (err_count widens by one bit).
module ram_checker #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(10'h0A5),
`ifdef RAM_CHECKER_INV_PASS_EN
    localparam int ERR_W = ADDR_W + 2
`else
    localparam int ERR_W = ADDR_W + 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    ram_checker_if.master     ram
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_DRAIN     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
`ifdef RAM_CHECKER_INV_PASS_EN
    localparam logic [2:0] S_WRITE_INV = 3'd5;
    localparam logic [2:0] S_READ_INV  = 3'd6;
`endif

    logic [2:0]        state;
    logic [1:0]        sel_q;
    logic              cmp_valid;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;
    logic              last;
    logic [ADDR_W-1:0] next_addr;
    logic              inv_rd;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        case (sel)
            2'd0:    w = '0;
            2'd1:    w = '1;
            // odd bits set on even addresses, even bits set on odd ones
            2'd2:    for (int i = 0; i < DATA_W; i++) w[i] = (i % 2 == 1) ^ a[0];
            default: w = DATA_W'(a) ^ SEED;
        endcase
        return w;
    endfunction

    // ram_addr doubles as the beat counter; all-ones marks the last beat of a phase
    assign last      = (ram.ram_addr == '1);
    assign next_addr = ram.ram_addr + 1'b1;
    assign mismatch  = cmp_valid && (ram.ram_dout != exp_q);
    assign err_next  = err_count + ERR_W'(mismatch);
`ifdef RAM_CHECKER_INV_PASS_EN
    assign inv_rd    = (state == S_READ_INV);
`else
    assign inv_rd    = 1'b0;
`endif

    // sequencer: state always describes the beat currently on the RAM pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            ram.ram_en   <= 1'b0;
            ram.ram_we   <= 1'b0;
            ram.ram_addr <= '0;
            ram.ram_din  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state        <= S_WRITE;
                    sel_q        <= pattern_sel;
                    pass         <= 1'b0;
                    busy         <= 1'b1;
                    ram.ram_en   <= 1'b1;
                    ram.ram_we   <= 1'b1;
                    ram.ram_addr <= '0;
                    ram.ram_din  <= pattern(pattern_sel, '0);
                end
                S_WRITE: if (last) begin
                    state        <= S_READ;
                    ram.ram_we   <= 1'b0;
                    ram.ram_addr <= '0;
                end else begin
                    ram.ram_addr <= next_addr;
                    ram.ram_din  <= pattern(sel_q, next_addr);
                end
                S_READ: if (last) begin
`ifdef RAM_CHECKER_INV_PASS_EN
                    state        <= S_WRITE_INV;
                    ram.ram_we   <= 1'b1;
                    ram.ram_addr <= '0;
                    ram.ram_din  <= ~pattern(sel_q, '0);
`else
                    state        <= S_DRAIN;
                    ram.ram_en   <= 1'b0;
`endif
                end else begin
                    ram.ram_addr <= next_addr;
                end
`ifdef RAM_CHECKER_INV_PASS_EN
                S_WRITE_INV: if (last) begin
                    state        <= S_READ_INV;
                    ram.ram_we   <= 1'b0;
                    ram.ram_addr <= '0;
                end else begin
                    ram.ram_addr <= next_addr;
                    ram.ram_din  <= ~pattern(sel_q, next_addr);
                end
                S_READ_INV: if (last) begin
                    state        <= S_DRAIN;
                    ram.ram_en   <= 1'b0;
                end else begin
                    ram.ram_addr <= next_addr;
                end
`endif
                // the last read's compare lands this cycle, so fold it into pass
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // compare pipeline: capture expected word on a read beat, check dout next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid      <= 1'b0;
            exp_q          <= '0;
            cmp_addr_q     <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            cmp_valid  <= ram.ram_en & ~ram.ram_we;
            exp_q      <= pattern(sel_q, ram.ram_addr) ^ {DATA_W{inv_rd}};
            cmp_addr_q <= ram.ram_addr;
            if (state == S_IDLE && start) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                err_count <= err_next;
                if (err_count == '0) first_err_addr <= cmp_addr_q;
            end
        end
    end
endmodule

// File: doc/ram_checker.md
# ram_checker

Built-in self-test initiator for the single-port 256x10 RAM block. On `start` it drives the RAM's port: it writes a selectable pattern to every address, then reads every address back and compares against the expected word. It reports pass/fail, an error count and the first failing address. It sits beside the RAM wrapper and owns the RAM's `en`/`we`/`addr`/`in` pins while `busy` is high.

## Interface
Parameters:
- `DATA_W`, default 10: RAM word width.
- `ADDR_W`, default 8: RAM address width (depth = 2^ADDR_W = 256).
- `SEED`, default 10'h0A5: XOR constant for pattern 3.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a test when sampled high in IDLE.
- `pattern_sel`, input, 2: pattern select, latched at start.
  - 0 = all zeros.
  - 1 = all ones.
  - 2 = checkerboard: 10'h2AA if addr[0]=0, else 10'h155.
  - 3 = {2'b00, addr} ^ SEED.
- `busy`, output, 1: test in progress.
- `done`, output, 1: one-cycle pulse at test completion.
- `pass`, output, 1: 1 if the last test had zero mismatches.
- `err_count`, output, ADDR_W+1: number of mismatching reads.
- `first_err_addr`, output, ADDR_W: address of the first mismatch. Stays 0 if there is none.
- `ram_en`, output, 1: RAM enable.
- `ram_we`, output, 1: RAM write enable.
- `ram_addr`, output, ADDR_W: RAM address.
- `ram_din`, output, DATA_W: RAM write data.
- `ram_dout`, input, DATA_W: RAM read data. Registered, valid one cycle after a read beat.

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE → IDLE.
  - With the macro enabled, READ → WRITE_INV → READ_INV → DRAIN.
- IDLE:
  - `start`=1 latches `pattern_sel`, clears `err_count` and `first_err_addr`, clears `pass`, and sets addr=0.
  - `start` in any other state is ignored.
- WRITE: each cycle issues `ram_en`=1, `ram_we`=1, `ram_din`=pattern(addr). Addr increments; after addr 255 the state moves to READ with addr=0.
- READ: each cycle issues `ram_en`=1, `ram_we`=0. Addr increments; after addr 255 the state moves to DRAIN.
- Compare pipeline:
  - Each read beat registers `cmp_valid` and the expected word (exp, addr).
  - On the next cycle `ram_dout` is compared with exp. This runs independently of state.
  - On a mismatch, `err_count` increments. If this is the first mismatch, `first_err_addr` captures the address.
- DRAIN: one cycle with `ram_en`=0, so the final read gets compared.
- DONE:
  - `done`=1 for one cycle and `pass` = (`err_count`==0), then return to IDLE.
  - `pass`, `err_count` and `first_err_addr` hold until the next accepted start.
- Address counter: ADDR_W bits. Wrap 255→0 is the phase-end condition, not an error.
- `err_count` maximum is 256 (512 with the macro, which needs ADDR_W+2 bits). It must not overflow: with the macro enabled, the port width is ADDR_W+2.
- Outside WRITE, READ, WRITE_INV and READ_INV:
  - `ram_en`=0 and `ram_we`=0.
  - `ram_addr` and `ram_din` hold their last values.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0. State = IDLE, compare pipeline cleared.
- Counting the edge that samples `start` as edge 0:
  - Write beats occupy cycles 1–256.
  - Read beats occupy cycles 257–512.
  - DRAIN is cycle 513.
  - `done`=1 in cycle 514.
- `busy` is high in cycles 1–513 and low in the `done` cycle.
- With the macro enabled:
  - Inverted writes occupy cycles 513–768.
  - Inverted reads occupy cycles 769–1024.
  - DRAIN is cycle 1025.
  - `done` is in cycle 1026.
- A new start is accepted in the cycle after `done` at the earliest.
- Reset mid-operation: on the next edge all outputs take their reset values (`ram_en`=0 immediately) and any pending compare is discarded.
- `rst` has priority over `start`.

## Configuration
- Macro: `RAM_CHECKER_INV_PASS_EN`.
- Defined: after READ, a second pass rewrites every address with the bitwise inverse of the pattern and reads it back with the same comparison. `err_count` is ADDR_W+2 bits.
- Undefined: single write/read pass only. The WRITE_INV and READ_INV states do not exist. `err_count` is ADDR_W+1 bits.

## Test plan
- Reset → all outputs 0. Hold `start`=0 for 10 cycles → `busy`=0, `ram_en`=0 throughout.
- Fault-free RAM model, pattern 0, `start` pulse → `done` at cycle 514, `pass`=1, `err_count`=0, `first_err_addr`=0. Exactly 256 write beats and 256 read beats observed.
- Pattern 1, RAM model with bit 3 stuck-at-0 at addr 8'h37 → `pass`=0, `err_count`=1, `first_err_addr`=8'h37.
- Pattern 3, SEED=10'h0A5 → write beat at addr 8'h10 has `ram_din`=10'h0B5. Pattern 2 at addr 8'h01 → 10'h155.
- `start` held high through the whole test → exactly one test runs. Reset asserted at cycle 100 → `ram_en`=0 and `busy`=0 next cycle; a fresh start then passes normally.
- Macro defined, fault-free model → `done` at cycle 1026, `pass`=1. Second-pass write at addr 0 with pattern 0 has `ram_din`=10'h3FF.
